// File: rtl/fir_coef_loader_if.sv
// Coefficient configuration channel between a configuration master and fir_coef_loader.
// A word transfers on a rising clk2 edge where cfg_valid and cfg_ready are both high. While
// cfg_valid is high, the master holds cfg_data and cfg_last stable until the word transfers.
// cfg_ready may change on any cycle without waiting for cfg_valid.
interface fir_coef_loader_if #(
  parameter int W = 16
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic signed [W-1:0] cfg_data;
  logic                cfg_last;

  modport master (
    output cfg_valid,
    output cfg_data,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    input  cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/fir_coef_loader.sv
// Buffers NTAP coefficients from the config channel, then releases the FIR ALU reset and
// streams one zero pad word followed by the taps on b_out before asserting b_valid.
module fir_coef_loader #(
  parameter int NTAP = 64,
  parameter int W    = 16,
  parameter int CW   = 7
) (
  input  logic                clk2,
  input  logic                COEF_restn,
  fir_coef_loader_if.slave    cfg,
  input  logic                reload,
  output logic                alu_restn,
  output logic signed [W-1:0] b_out,
  output logic                b_valid,
  output logic                busy,
  output logic                err,
  output logic [1:0]          dbg_state
);

  localparam int AW = $clog2(NTAP);
  localparam logic [CW-1:0] LAST_IDX   = CW'(NTAP - 1);
  localparam logic [CW-1:0] STREAM_END = CW'(NTAP);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_STREAM = 2'd1,
    S_RUN    = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       wcnt_q;
  logic [CW-1:0]       scnt_q;
  logic                alu_restn_q;
  logic                b_valid_q;
  logic                err_q;
  logic signed [W-1:0] b_out_q;
  logic signed [W-1:0] buf_q [NTAP];

  logic                accept;
  logic signed [W-1:0] rd_word;

  assign cfg.cfg_ready = (state_q == S_LOAD);
  assign busy          = (state_q == S_LOAD) || (state_q == S_STREAM);
  // reload wins over a same-cycle handshake, so the offered word is dropped.
  assign accept        = cfg.cfg_valid && cfg.cfg_ready && !reload;
  assign rd_word       = buf_q[scnt_q[AW-1:0]];

  assign alu_restn = alu_restn_q;
  assign b_out     = b_out_q;
  assign b_valid   = b_valid_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  // Coefficient storage has no reset; it is always fully rewritten before being streamed.
  always_ff @(posedge clk2) begin
    if (accept) begin
      buf_q[wcnt_q[AW-1:0]] <= cfg.cfg_data;
    end
  end

  always_ff @(posedge clk2 or negedge COEF_restn) begin
    if (!COEF_restn) begin
      state_q     <= S_LOAD;
      wcnt_q      <= '0;
      scnt_q      <= '0;
      alu_restn_q <= 1'b0;
      b_out_q     <= '0;
      b_valid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else if (reload) begin
      state_q     <= S_LOAD;
      wcnt_q      <= '0;
      scnt_q      <= '0;
      alu_restn_q <= 1'b0;
      b_out_q     <= '0;
      b_valid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          alu_restn_q <= 1'b0;
          b_valid_q   <= 1'b0;
          b_out_q     <= '0;
          if (accept) begin
            wcnt_q <= wcnt_q + CW'(1);
            if (cfg.cfg_last && (wcnt_q == LAST_IDX)) begin
              // Leaving LOAD: scnt = 0 drives the pad word the ALU discards.
              state_q     <= S_STREAM;
              scnt_q      <= '0;
              alu_restn_q <= 1'b1;
            end else if (cfg.cfg_last || (wcnt_q == LAST_IDX)) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (scnt_q == STREAM_END) begin
            state_q   <= S_RUN;
            b_out_q   <= '0;
            b_valid_q <= 1'b1;
          end else begin
            b_out_q <= rd_word;
            scnt_q  <= scnt_q + CW'(1);
          end
        end
        S_RUN: begin
          alu_restn_q <= 1'b1;
          b_valid_q   <= 1'b1;
          b_out_q     <= '0;
        end
        default: begin
          alu_restn_q <= 1'b0;
          b_valid_q   <= 1'b0;
          b_out_q     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: randomized loads compared against a queue-based model.
module tb_fir_coef_loader;
  localparam int NTAP = 64;
  localparam int W    = 16;

  logic         clk2 = 1'b0;
  logic         COEF_restn = 1'b0;
  logic         reload = 1'b0;
  logic         alu_restn;
  logic [W-1:0] b_out;
  logic         b_valid;
  logic         busy;
  logic         err;
  logic [1:0]   dbg_state;

  fir_coef_loader_if #(.W(W)) cfg_if ();

  fir_coef_loader #(.NTAP(NTAP), .W(W), .CW(7)) dut (
    .clk2       (clk2),
    .COEF_restn (COEF_restn),
    .cfg        (cfg_if),
    .reload     (reload),
    .alu_restn  (alu_restn),
    .b_out      (b_out),
    .b_valid    (b_valid),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk2 = ~clk2;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] coefs [NTAP];
  logic [W-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk2);
  endtask

  // Reference model: the ALU sees one zero pad word, then every coefficient in load order.
  task automatic build_expected();
    exp_q.delete();
    exp_q.push_back('0);
    for (int i = 0; i < NTAP; i++) exp_q.push_back(coefs[i]);
  endtask

  // driver tasks
  task automatic send_word(input logic [W-1:0] d, input bit last);
    int budget;
    budget = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = d;
    cfg_if.cfg_last  = last;
    while (!cfg_if.cfg_ready && budget < 100) begin
      tick();
      budget++;
    end
    if (budget >= 100) check_eq("ready_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic idle_cycle();
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = $urandom_range(0, 1);
    cfg_if.cfg_data  = W'($urandom);
    tick();
  endtask

  // gap_mode: 0 = back-to-back, 1 = alternate idle, 2 = random idles. last_at < 0: never set last.
  task automatic load_seq(input int last_at, input int gap_mode);
    for (int i = 0; i < NTAP; i++) begin
      if (gap_mode == 1 && i > 0) idle_cycle();
      if (gap_mode == 2 && $urandom_range(0, 2) == 0) idle_cycle();
      send_word(coefs[i], i == last_at);
      if (i == last_at) break;
    end
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NTAP; i++) coefs[i] = W'($urandom);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  // scoreboard: called at the negedge right after the final accept
  task automatic check_stream(input string tag);
    for (int k = 0; k <= NTAP; k++) begin
      check_eq({tag, "_b_out"}, 32'(b_out), 32'(exp_q.pop_front()));
      if (k == 0) begin
        check_eq({tag, "_alu_restn_rise"}, 32'(alu_restn), 32'd1);
        check_eq({tag, "_b_valid_low"}, 32'(b_valid), 32'd0);
        check_eq({tag, "_ready_low"}, 32'(cfg_if.cfg_ready), 32'd0);
        check_eq({tag, "_busy_stream"}, 32'(busy), 32'd1);
      end
      if (k == NTAP) check_eq({tag, "_b_valid_early"}, 32'(b_valid), 32'd0);
      tick();
    end
    check_eq({tag, "_b_valid_run"}, 32'(b_valid), 32'd1);
    check_eq({tag, "_b_out_run"}, 32'(b_out), 32'd0);
    check_eq({tag, "_busy_run"}, 32'(busy), 32'd0);
    check_eq({tag, "_err_run"}, 32'(err), 32'd0);
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    cfg_if.cfg_last  = 1'b0;
    repeat (2) tick();
    check_eq("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    check_eq("rst_alu_restn", 32'(alu_restn), 32'd0);
    check_eq("rst_b_out", 32'(b_out), 32'd0);
    check_eq("rst_b_valid", 32'(b_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_err", 32'(err), 32'd0);
    COEF_restn = 1'b1;
    tick();

    // normal load 1..64
    for (int i = 0; i < NTAP; i++) coefs[i] = W'(i + 1);
    build_expected();
    load_seq(NTAP - 1, 0);
    check_stream("normal");

    // backpressured, -1..-64
    pulse_reload();
    for (int i = 0; i < NTAP; i++) coefs[i] = W'(-(i + 1));
    build_expected();
    load_seq(NTAP - 1, 1);
    check_stream("bp");

    // early last on word 10, then a random early position
    for (int rep = 0; rep < 2; rep++) begin
      int pos;
      pos = (rep == 0) ? 9 : int'($urandom_range(0, NTAP - 2));
      pulse_reload();
      check_eq("early_pre_ready", 32'(cfg_if.cfg_ready), 32'd1);
      fill_random();
      load_seq(pos, 0);
      check_eq("early_err", 32'(err), 32'd1);
      check_eq("early_alu_restn", 32'(alu_restn), 32'd0);
      check_eq("early_ready", 32'(cfg_if.cfg_ready), 32'd0);
      check_eq("early_b_valid", 32'(b_valid), 32'd0);
      check_eq("early_busy", 32'(busy), 32'd0);
      pulse_reload();
      check_eq("early_reload_err", 32'(err), 32'd0);
      check_eq("early_reload_ready", 32'(cfg_if.cfg_ready), 32'd1);
    end

    // missing last
    fill_random();
    load_seq(-1, 2);
    check_eq("miss_err", 32'(err), 32'd1);
    check_eq("miss_alu_restn", 32'(alu_restn), 32'd0);
    repeat (70) tick();
    check_eq("miss_no_stream", 32'(alu_restn), 32'd0);
    check_eq("miss_no_valid", 32'(b_valid), 32'd0);
    check_eq("miss_err_hold", 32'(err), 32'd1);
    pulse_reload();

    // random load, then reload in RUN with a simultaneous offered word
    fill_random();
    build_expected();
    load_seq(NTAP - 1, 2);
    check_stream("rand");
    reload = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 16'h5555;
    cfg_if.cfg_last  = 1'b1;
    tick();
    reload = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
    check_eq("rl_ready", 32'(cfg_if.cfg_ready), 32'd1);
    check_eq("rl_b_valid", 32'(b_valid), 32'd0);
    check_eq("rl_alu_restn", 32'(alu_restn), 32'd0);
    check_eq("rl_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NTAP; i++) coefs[i] = W'(100 + i);
    build_expected();
    load_seq(NTAP - 1, 0);
    check_stream("reload2");

    // async reset at scnt = 30
    pulse_reload();
    fill_random();
    build_expected();
    load_seq(NTAP - 1, 0);
    for (int k = 0; k <= 30; k++) begin
      check_eq("ar_b_out", 32'(b_out), 32'(exp_q.pop_front()));
      if (k < 30) tick();
    end
    #1 COEF_restn = 1'b0;
    #1;
    check_eq("ar_alu_restn", 32'(alu_restn), 32'd0);
    check_eq("ar_b_out_zero", 32'(b_out), 32'd0);
    check_eq("ar_b_valid", 32'(b_valid), 32'd0);
    check_eq("ar_ready", 32'(cfg_if.cfg_ready), 32'd1);
    tick();
    COEF_restn = 1'b1;
    repeat (5) tick();
    check_eq("ar_post_alu_restn", 32'(alu_restn), 32'd0);
    check_eq("ar_post_ready", 32'(cfg_if.cfg_ready), 32'd1);
    check_eq("ar_post_busy", 32'(busy), 32'd1);
    fill_random();
    build_expected();
    load_seq(NTAP - 1, 2);
    check_stream("ar_full");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
- Upstream stage of the 64-tap FIR ALU.
- Accepts 64 signed 16-bit coefficients from a configuration master over a valid/ready handshake and holds them in a local buffer.
- Owns the ALU's reset and drives the ALU's serial coefficient port `b` with the exact cycle alignment the ALU expects: one discarded pad cycle after reset release, then 64 coefficients.
- Once streaming completes, raises `b_valid` so the ALU starts accepting samples.
- Supports reload without a global reset.

Parameters:
- NTAP, 64, number of coefficients (ALU tap count).
- W, 16, coefficient width in bits.
- CW, 7, counter width; must satisfy 2^CW > NTAP.

Ports:
- clk2  input  1  coefficient clock, same clock as the ALU coefficient path.
- COEF_restn  input  1  asynchronous active-low reset.
- cfg_valid  input  1  coefficient word offered.
- cfg_ready  output  1  loader accepts a word this cycle.
- cfg_data  input  W  signed coefficient, tap 0 first.
- cfg_last  input  1  marks the final word of a load.
- reload  input  1  single-cycle pulse; restarts the load sequence.
- alu_restn  output  1  registered active-low reset driven to the ALU.
- b_out  output  W  coefficient stream to the ALU `b` port.
- b_valid  output  1  to the ALU `b_valid`; high only in RUN.
- busy  output  1  high in LOAD or STREAM.
- err  output  1  sticky framing error.

Behaviour:
- Clock and reset: one clock, `clk2`; reset `COEF_restn` is asynchronous and active-low.
- Reset values:
  - state = LOAD, word count = 0, stream count = 0.
  - cfg_ready = 1, alu_restn = 0, b_out = 0, b_valid = 0, busy = 1, err = 0.
  - Buffer contents are not reset.
- All outputs are registered except cfg_ready and busy, which decode the state.
- States: LOAD, STREAM, RUN, ERR.
- LOAD:
  - cfg_ready = 1; alu_restn = 0; b_valid = 0.
  - A word is accepted on a cycle with cfg_valid & cfg_ready: buf[wcnt] <= cfg_data and wcnt increments.
  - Accepted word with wcnt == NTAP-1 and cfg_last = 1: go to STREAM and clear scnt.
  - Accepted word with cfg_last = 1 and wcnt < NTAP-1: go to ERR, err <= 1.
  - Accepted word with wcnt == NTAP-1 and cfg_last = 0: go to ERR, err <= 1.
  - cfg_last is ignored on cycles where cfg_valid = 0.
- STREAM:
  - cfg_ready = 0; alu_restn = 1 from the first STREAM cycle.
  - scnt runs 0..NTAP. In each cycle, b_out is driven with a value the ALU samples at the next edge:
    - scnt = 0: pad value 0 (consumed by the ALU's discard cycle).
    - scnt = k, 1 ≤ k ≤ NTAP: buf[k-1].
  - Exactly NTAP+1 = 65 STREAM cycles; after scnt == NTAP, go to RUN.
- RUN:
  - b_valid = 1; b_out held at 0; alu_restn = 1; cfg_ready = 0.
  - Stays in RUN until reload.
- ERR:
  - cfg_ready = 0, alu_restn = 0, b_valid = 0.
  - Leaves only on reload.
- reload:
  - Accepted in any state.
  - Next cycle: state = LOAD, wcnt = 0, scnt = 0, err = 0, alu_restn = 0, b_valid = 0.
  - reload has priority over any handshake or count completion in the same cycle; a word offered in that cycle is not accepted.
- Latency: from the accepting edge of the last word to b_valid rising is 66 clk2 edges (65 STREAM cycles plus the transition edge).
- busy = 1 in LOAD or STREAM; 0 in RUN and ERR.
- Asynchronous reset mid-operation (including mid-STREAM): immediate return to the reset values. alu_restn drops without waiting for a clock edge.
- Arithmetic: coefficients pass through unmodified; no scaling or saturation.
- Back-to-back accepted words are allowed every cycle. Gaps with cfg_valid = 0 hold wcnt.

Test Plan:
- Normal load: coefficients 1..64, cfg_valid held high, cfg_last on word 64 → alu_restn rises one cycle after the last accept; b_out = 0, 1, 2, …, 64 over 65 consecutive cycles; b_valid = 1 on the 66th edge; err = 0.
- Backpressured master: coefficients -1, -2, …, -64 with cfg_valid toggling 1,0,1,0 → identical stream (0, then -1..-64); wcnt advances only on accepts.
- Early last: cfg_last on word 10 → err = 1 next cycle; alu_restn stays 0; cfg_ready = 0; b_valid = 0. Then a reload pulse → err = 0, cfg_ready = 1.
- Missing last: 64 words with cfg_last = 0 → err = 1 after word 64; no streaming occurs.
- Reload in RUN: after a normal load, pulse reload with cfg_valid = 1 in the same cycle → that word is not accepted; next cycle state = LOAD, b_valid = 0, alu_restn = 0. A second load with 100..163 streams 0, 100..163.
- Async reset at scnt = 30: COEF_restn low mid-cycle → alu_restn = 0 and b_out = 0 immediately. After release, cfg_ready = 1 and a full load is required before any streaming.
